// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one external combinational W-bit ALU between two
// requesters. Round-robin arbitration, single-cycle ADD/SUB/NOT, and W-cycle
// shift-add MUL built on the ALU adder. Result and done are registered.
module alu_op_scheduler #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic [1:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result
);

  localparam int unsigned SW = (W > 1) ? $clog2(W) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  // ALU Control encodings
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NOTB = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic           seen_q, seen_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [SW-1:0]  step_q, step_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           done_id_q, done_id_d;

  logic           any_req;
  logic           win;
  op_t            win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic [W-1:0]   mul_acc_next;
  logic           mul_last;

  // Arbitration: on a tie, favour the requester not granted last time. Until
  // the first grant after reset there is no "last", so requester 0 wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = seen_q ? ~rr_ptr_q : 1'b0;
    end else begin
      win = req1;
    end
    win_op = win ? op_t'(op1) : op_t'(op0);
    win_a  = win ? a1 : a0;
    win_b  = win ? b1 : b0;
  end

  // Shift-add step: accumulate the ALU sum only when the current multiplier bit is set
  always_comb begin
    mul_acc_next = b_q[step_q] ? alu_result : acc_q;
    mul_last     = (step_q == LAST_STEP);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = (win_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
      end
      S_MUL: begin
        if (mul_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: grant, busy and the ALU drive
  always_comb begin
    gnt      = 2'b00;
    busy     = (state_q != S_IDLE);
    alu_ctrl = ALU_ZERO;
    alu_a    = '0;
    alu_b    = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt = win ? 2'b10 : 2'b01;
        end
      end
      S_EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          OP_ADD:  alu_ctrl = ALU_ADD;
          OP_SUB:  alu_ctrl = ALU_SUB;
          OP_NOT:  alu_ctrl = ALU_NOTB;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_MUL: begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = a_q << step_q;
      end
      default: begin
        alu_ctrl = ALU_ZERO;
      end
    endcase
  end

  // Datapath next-state: operand latch on grant, accumulate during MUL, publish result on completion
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    seen_d    = seen_q;
    acc_d     = acc_q;
    step_d    = step_q;
    result_d  = result_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          op_d     = win_op;
          a_d      = win_a;
          b_d      = win_b;
          id_d     = win;
          rr_ptr_d = win;
          seen_d   = 1'b1;
          acc_d    = '0;
          step_d   = '0;
        end
      end
      S_EXEC: begin
        result_d  = alu_result;
        done_d    = 1'b1;
        done_id_d = id_q;
      end
      S_MUL: begin
        acc_d  = mul_acc_next;
        step_d = step_q + 1'b1;
        if (mul_last) begin
          result_d  = mul_acc_next;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset also aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rr_ptr_q  <= 1'b0;
      seen_q    <= 1'b0;
      acc_q     <= '0;
      step_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      seen_q    <= seen_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      result_q  <= result_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed testbench for alu_op_scheduler (W=4) with a behavioural ALU attached.
module tb_alu_op_scheduler;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic [1:0]   gnt;
  logic         busy, done, done_id;
  logic [W-1:0] result;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;

  int n_vec = 0;
  int n_err = 0;

  alu_op_scheduler #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .op0        (op0),
    .op1        (op1),
    .a0         (a0),
    .a1         (a1),
    .b0         (b0),
    .b1         (b1),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .result     (result),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // Shared ALU model
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = ~alu_b;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the middle of the next cycle; inputs change here, then settle 1 time unit
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    op0 = 2'b00; op1 = 2'b00; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_done_id", done_id, 0);
    check("rst_gnt", gnt, 0);
    check("rst_alu_ctrl", alu_ctrl, 2'b11);

    // 1: ADD 9+8 = 1 (mod 16)
    req0 = 1; op0 = 2'b00; a0 = 9; b0 = 8; #1;
    check("t1_gnt", gnt, 2'b01);
    check("t1_busy0", busy, 0);
    nxt(); req0 = 0; a0 = 0; b0 = 0; #1;
    check("t1_busy1", busy, 1);
    check("t1_gnt1", gnt, 0);
    check("t1_ctrl", alu_ctrl, 2'b00);
    check("t1_alu_a", alu_a, 9);
    check("t1_alu_b", alu_b, 8);
    nxt(); #1;
    check("t1_done", done, 1);
    check("t1_id", done_id, 0);
    check("t1_result", result, 1);
    check("t1_busy2", busy, 0);
    nxt(); #1;
    check("t1_done_low", done, 0);
    check("t1_result_hold", result, 1);

    // 2: SUB 3-5 = 14
    req1 = 1; op1 = 2'b01; a1 = 3; b1 = 5; #1;
    check("t2_gnt", gnt, 2'b10);
    nxt(); req1 = 0; #1;
    check("t2_ctrl", alu_ctrl, 2'b01);
    nxt(); #1;
    check("t2_done", done, 1);
    check("t2_id", done_id, 1);
    check("t2_result", result, 14);

    // 3: MUL 7*6 = 42 -> 10; operands changed after grant must be ignored
    nxt();
    req0 = 1; op0 = 2'b10; a0 = 7; b0 = 6; #1;
    check("t3_gnt", gnt, 2'b01);
    nxt(); req0 = 0; a0 = 15; b0 = 0; op0 = 2'b01; #1;
    check("t3_busy_s0", busy, 1);
    check("t3_ctrl_s0", alu_ctrl, 2'b00);
    check("t3_a_s0", alu_a, 0);
    check("t3_b_s0", alu_b, 7);
    check("t3_done_s0", done, 0);
    nxt(); #1;
    check("t3_ctrl_s1", alu_ctrl, 2'b00);
    check("t3_a_s1", alu_a, 0);
    check("t3_b_s1", alu_b, 14);
    nxt(); #1;
    check("t3_ctrl_s2", alu_ctrl, 2'b00);
    check("t3_a_s2", alu_a, 14);
    check("t3_b_s2", alu_b, 12);
    nxt(); #1;
    check("t3_ctrl_s3", alu_ctrl, 2'b00);
    check("t3_busy_s3", busy, 1);
    check("t3_a_s3", alu_a, 10);
    check("t3_b_s3", alu_b, 8);
    check("t3_done_s3", done, 0);
    nxt(); #1;
    check("t3_done", done, 1);
    check("t3_busy_end", busy, 0);
    check("t3_id", done_id, 0);
    check("t3_result", result, 10);

    // 4: both held from reset: grants 0,1,0; NOT 5 = 10, ADD 1+1 = 2
    do_reset();
    req0 = 1; op0 = 2'b11; a0 = 3; b0 = 5;
    req1 = 1; op1 = 2'b00; a1 = 1; b1 = 1; #1;
    check("t4_gnt_a", gnt, 2'b01);
    nxt(); #1;
    check("t4_gnt_busy", gnt, 0);
    check("t4_ctrl_not", alu_ctrl, 2'b10);
    nxt(); #1;
    check("t4_done_a", done, 1);
    check("t4_res_a", result, 10);
    check("t4_id_a", done_id, 0);
    check("t4_gnt_b", gnt, 2'b10);
    nxt(); #1;
    check("t4_ctrl_add", alu_ctrl, 2'b00);
    nxt(); #1;
    check("t4_done_b", done, 1);
    check("t4_res_b", result, 2);
    check("t4_id_b", done_id, 1);
    check("t4_gnt_c", gnt, 2'b01);
    nxt(); req0 = 0; req1 = 0; #1;
    nxt(); #1;
    check("t4_res_c", result, 10);
    check("t4_id_c", done_id, 0);

    // 5: req1 raised during MUL 3*3 waits until the done cycle; then ADD 2+3
    nxt();
    req0 = 1; op0 = 2'b10; a0 = 3; b0 = 3; #1;
    check("t5_gnt0", gnt, 2'b01);
    nxt(); req0 = 0; #1;
    nxt(); req1 = 1; op1 = 2'b00; a1 = 2; b1 = 3; #1;
    check("t5_gnt_s1", gnt, 0);
    nxt(); #1;
    check("t5_gnt_s2", gnt, 0);
    nxt(); #1;
    check("t5_gnt_s3", gnt, 0);
    check("t5_busy_s3", busy, 1);
    nxt(); #1;
    check("t5_done_mul", done, 1);
    check("t5_res_mul", result, 9);
    check("t5_gnt_done", gnt, 2'b10);
    nxt(); req1 = 0; #1;
    nxt(); #1;
    check("t5_done_add", done, 1);
    check("t5_res_add", result, 5);
    check("t5_id_add", done_id, 1);

    // 6: reset at MUL step 2 aborts; a fresh request is then served
    nxt();
    req0 = 1; op0 = 2'b10; a0 = 7; b0 = 6; #1;
    check("t6_gnt", gnt, 2'b01);
    nxt(); req0 = 0; #1;
    nxt(); #1;
    nxt(); #1;
    check("t6_b_s2", alu_b, 12);
    rst_n = 0;
    nxt(); rst_n = 1;
    req1 = 1; op1 = 2'b00; a1 = 4; b1 = 5; #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_result", result, 0);
    check("t6_id", done_id, 0);
    check("t6_gnt_new", gnt, 2'b10);
    nxt(); req1 = 0; #1;
    check("t6_no_done", done, 0);
    check("t6_result_hold", result, 0);
    nxt(); #1;
    check("t6_done_new", done, 1);
    check("t6_res_new", result, 9);
    check("t6_id_new", done_id, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
